// File: rtl/vga_timing_pkg.sv
// Shared constants, region type and sizing helpers for the VGA raster timing generator.
package vga_timing_pkg;

   localparam int unsigned VGA_H_ACTIVE = 640;
   localparam int unsigned VGA_H_FP     = 16;
   localparam int unsigned VGA_H_SYNC   = 96;
   localparam int unsigned VGA_H_BP     = 48;
   localparam int unsigned VGA_V_ACTIVE = 480;
   localparam int unsigned VGA_V_FP     = 10;
   localparam int unsigned VGA_V_SYNC   = 2;
   localparam int unsigned VGA_V_BP     = 33;

   typedef enum logic [1:0] {
      REG_ACTIVE,
      REG_FP,
      REG_SYNC,
      REG_BP
   } region_e;

   function automatic int unsigned total(input int unsigned active, input int unsigned fp,
                                         input int unsigned sync, input int unsigned bp);
      return active + fp + sync + bp;
   endfunction

   // Counter width for a modulus of n; never narrower than one bit.
   function automatic int unsigned width_for(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic region_e region_of(input int unsigned pos, input int unsigned active,
                                         input int unsigned fp, input int unsigned sync);
      if (pos < active)             return REG_ACTIVE;
      if (pos < active + fp)        return REG_FP;
      if (pos < active + fp + sync) return REG_SYNC;
      return REG_BP;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap detection and region decode of the next position.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int unsigned ACTIVE = VGA_H_ACTIVE,
   parameter int unsigned FP     = VGA_H_FP,
   parameter int unsigned SYNC   = VGA_H_SYNC,
   parameter int unsigned BP     = VGA_H_BP,
   parameter bit          POL    = 1'b0,
   localparam int unsigned TOTAL = total(ACTIVE, FP, SYNC, BP),
   localparam int unsigned W     = width_for(TOTAL)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         step_i,
   input  logic         clear_i,
   output logic [W-1:0] pos_o,
   output logic         wrap_o,
   output logic         active_o,
   output logic         sync_next_o
);

   localparam logic [W-1:0] LAST = W'(TOTAL - 1);

   logic [W-1:0] pos_q, pos_d;
   region_e      region_next;

   assign wrap_o = step_i && !clear_i && (pos_q == LAST);

   always_comb begin
      // NOTE: default assigned first so every path drives pos_d and no latch is inferred.
      pos_d = pos_q;
      if (clear_i) begin
         pos_d = LAST;
      end else if (step_i) begin
         pos_d = (pos_q == LAST) ? '0 : pos_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!rst_n) pos_q <= LAST;
      else        pos_q <= pos_d;
   end

   // Decoding the next position lets the parent register these in step with pos.
   assign region_next = region_of(int'(pos_d), ACTIVE, FP, SYNC);
   assign active_o    = (region_next == REG_ACTIVE);
   assign sync_next_o = (region_next == REG_SYNC) ? POL : ~POL;
   assign pos_o       = pos_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel prescaler, enable/freeze and strobes.
// Optional frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE  = VGA_H_ACTIVE,
   parameter int unsigned H_FP      = VGA_H_FP,
   parameter int unsigned H_SYNC    = VGA_H_SYNC,
   parameter int unsigned H_BP      = VGA_H_BP,
   parameter int unsigned V_ACTIVE  = VGA_V_ACTIVE,
   parameter int unsigned V_FP      = VGA_V_FP,
   parameter int unsigned V_SYNC    = VGA_V_SYNC,
   parameter int unsigned V_BP      = VGA_V_BP,
   parameter bit          HSYNC_POL = 1'b0,
   parameter bit          VSYNC_POL = 1'b0,
   parameter int unsigned CLK_DIV   = 1,
   parameter int unsigned FRAME_W   = 8,
   localparam int unsigned H_TOTAL  = total(H_ACTIVE, H_FP, H_SYNC, H_BP),
   localparam int unsigned V_TOTAL  = total(V_ACTIVE, V_FP, V_SYNC, V_BP),
   localparam int unsigned HW       = width_for(H_TOTAL),
   localparam int unsigned VW       = width_for(V_TOTAL)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena_i,
   output logic               pix_stb_o,
   output logic [HW-1:0]      hpos_o,
   output logic [VW-1:0]      vpos_o,
   output logic               display_on_o,
   output logic               hsync_o,
   output logic               vsync_o,
   output logic               line_start_o,
   output logic               frame_start_o,
   output logic [FRAME_W-1:0] frame_cnt_o
);

   if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0
       || CLK_DIV == 0) begin : g_param_check
      $error("vga_timing_gen: porch/sync widths and CLK_DIV must all be non-zero");
   end

   localparam int unsigned       DIV_W    = width_for(CLK_DIV);
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic             pix_stb;
   logic             h_wrap, h_active_next, h_sync_next;
   logic             v_wrap, v_active_next, v_sync_next;
   logic             display_on_q, hsync_q, vsync_q, line_start_q, frame_start_q;

   assign pix_stb = ena_i && (div_cnt_q == DIV_LAST);

   always_comb begin
      div_cnt_d = div_cnt_q;
      if (ena_i) div_cnt_d = pix_stb ? '0 : div_cnt_q + 1'b1;
   end

   vga_axis_counter #(
      .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HSYNC_POL)
   ) u_h_axis (
      .clk(clk), .rst_n(rst_n), .step_i(pix_stb), .clear_i(1'b0),
      .pos_o(hpos_o), .wrap_o(h_wrap), .active_o(h_active_next), .sync_next_o(h_sync_next)
   );

   // The vertical axis advances only on the horizontal wrap.
   vga_axis_counter #(
      .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VSYNC_POL)
   ) u_v_axis (
      .clk(clk), .rst_n(rst_n), .step_i(h_wrap), .clear_i(1'b0),
      .pos_o(vpos_o), .wrap_o(v_wrap), .active_o(v_active_next), .sync_next_o(v_sync_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q     <= '0;
         display_on_q  <= 1'b0;
         hsync_q       <= ~HSYNC_POL;
         vsync_q       <= ~VSYNC_POL;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         div_cnt_q     <= div_cnt_d;
         display_on_q  <= h_active_next && v_active_next;
         hsync_q       <= h_sync_next;
         vsync_q       <= v_sync_next;
         line_start_q  <= h_wrap;
         frame_start_q <= h_wrap && v_wrap;
      end
   end

`ifdef VGA_TIMING_FRAME_CNT_EN
   logic               started_q;
   logic [FRAME_W-1:0] frame_cnt_q;

   // The wrap out of the reset position is not a completed frame, so it only arms the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         started_q   <= 1'b0;
         frame_cnt_q <= '0;
      end else if (v_wrap) begin
         started_q <= 1'b1;
         if (started_q) frame_cnt_q <= frame_cnt_q + 1'b1;
      end
   end

   assign frame_cnt_o = frame_cnt_q;
`else
   assign frame_cnt_o = '0;
`endif

   assign pix_stb_o     = pix_stb;
   assign display_on_o  = display_on_q;
   assign hsync_o       = hsync_q;
   assign vsync_o       = vsync_q;
   assign line_start_o  = line_start_q;
   assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: small test raster with CLK_DIV=2 plus a default 640x480 instance.
module tb_vga_timing_gen;

   localparam int HA = 8, HFP = 2, HS = 3, HBP = 1;
   localparam int VA = 4, VFP = 1, VS = 2, VBP = 1;
   localparam int DIV = 2;
   localparam int HT = HA + HFP + HS + HBP;
   localparam int VT = VA + VFP + VS + VBP;
`ifdef VGA_TIMING_FRAME_CNT_EN
   localparam bit FC_EN = 1'b1;
`else
   localparam bit FC_EN = 1'b0;
`endif

   logic       clk, rst_n, ena;
   logic       pix_stb, display_on, hsync, vsync, line_start, frame_start;
   logic [3:0] hpos;
   logic [2:0] vpos;
   logic [7:0] frame_cnt;

   logic       d_pix_stb, d_display_on, d_hsync, d_vsync, d_line_start, d_frame_start;
   logic [9:0] d_hpos, d_vpos;
   logic [7:0] d_frame_cnt;

   int checks   = 0;
   int failures = 0;

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CLK_DIV(DIV), .FRAME_W(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ena_i(ena), .pix_stb_o(pix_stb),
      .hpos_o(hpos), .vpos_o(vpos), .display_on_o(display_on),
      .hsync_o(hsync), .vsync_o(vsync), .line_start_o(line_start),
      .frame_start_o(frame_start), .frame_cnt_o(frame_cnt)
   );

   vga_timing_gen dut_def (
      .clk(clk), .rst_n(rst_n), .ena_i(1'b1), .pix_stb_o(d_pix_stb),
      .hpos_o(d_hpos), .vpos_o(d_vpos), .display_on_o(d_display_on),
      .hsync_o(d_hsync), .vsync_o(d_vsync), .line_start_o(d_line_start),
      .frame_start_o(d_frame_start), .frame_cnt_o(d_frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, failures so far=%0d", failures);
      $fatal(1, "watchdog expired");
   end

   // Advance to the next cycle, drive ena for it and sample shortly after.
   task automatic step(input logic en);
      @(negedge clk);
      ena = en;
      #1;
   endtask

   // Leaves the bench sampling cycle 0 right after release, ena high.
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      ena   = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      ena   = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if ({pix_stb, hpos, vpos, display_on, hsync, vsync, line_start, frame_start, frame_cnt}
          !== {1'b0, 4'(HT-1), 3'(VT-1), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}) begin
         failures++;
         $display("FAIL reset_state: got stb=%b h=%0d v=%0d de=%b hs=%b vs=%b ls=%b fs=%b fc=%0d, want 0 13 7 0 1 1 0 0 0",
                  pix_stb, hpos, vpos, display_on, hsync, vsync, line_start, frame_start, frame_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if ({pix_stb, hpos} !== {1'b0, 4'(HT-1)}) begin
         failures++;
         $display("FAIL release_cycle0: got stb=%b h=%0d, want stb=0 h=13", pix_stb, hpos);
      end
      step(1'b1);
      checks++;
      if ({pix_stb, hpos} !== {1'b1, 4'(HT-1)}) begin
         failures++;
         $display("FAIL first_stb_cycle1: got stb=%b h=%0d, want stb=1 h=13", pix_stb, hpos);
      end
      step(1'b1);
      checks++;
      if ({pix_stb, hpos, vpos, line_start, frame_start, display_on, frame_cnt}
          !== {1'b0, 4'd0, 3'd0, 1'b1, 1'b1, 1'b1, 8'd0}) begin
         failures++;
         $display("FAIL first_origin: got stb=%b h=%0d v=%0d ls=%b fs=%b de=%b fc=%0d, want 0 0 0 1 1 1 0",
                  pix_stb, hpos, vpos, line_start, frame_start, display_on, frame_cnt);
      end
      step(1'b1);
      checks++;
      if ({line_start, frame_start, hpos} !== {1'b0, 1'b0, 4'd0}) begin
         failures++;
         $display("FAIL strobe_width: got ls=%b fs=%b h=%0d, want 0 0 0", line_start, frame_start, hpos);
      end
      step(1'b1);
      step(1'b1);
      checks++;
      if (hpos !== 4'd1) begin
         failures++;
         $display("FAIL second_pixel: got h=%0d, want 1", hpos);
      end
   endtask

   task automatic test_line();
      int first_ls = -1, second_ls = -1, hs_low = 0, bad_hs = 0, bad_de = 0;
      do_reset();
      for (int c = 0; c < 120 && second_ls < 0; c++) begin
         if (c > 0) step(1'b1);
         if (line_start === 1'b1) begin
            if (first_ls < 0) first_ls = c;
            else              second_ls = c;
         end
         if (first_ls >= 0 && second_ls < 0) begin
            if (hsync === 1'b0) begin
               hs_low++;
               if (hpos < 4'd10 || hpos > 4'd12) bad_hs++;
            end
            if (display_on !== (hpos < 4'd8)) bad_de++;
         end
      end
      checks++;
      if (first_ls != 2) begin
         failures++;
         $display("FAIL line_first_ls: got cycle %0d, want 2", first_ls);
      end
      checks++;
      if (second_ls - first_ls != HT * DIV) begin
         failures++;
         $display("FAIL line_period: got %0d cycles, want %0d", second_ls - first_ls, HT * DIV);
      end
      checks++;
      if (hs_low != HS * DIV || bad_hs != 0) begin
         failures++;
         $display("FAIL hsync_window: got %0d low cycles (%0d outside 10..12), want 6 (0)", hs_low, bad_hs);
      end
      checks++;
      if (bad_de != 0) begin
         failures++;
         $display("FAIL display_on_line: got %0d cycles disagreeing with hpos<8, want 0", bad_de);
      end
   endtask

   task automatic test_frame();
      int f1 = -1, f2 = -1, vs_low = 0, bad_vs = 0;
      logic [7:0] fc1 = 8'hxx, fc2 = 8'hxx;
      do_reset();
      for (int c = 0; c < 600 && f2 < 0; c++) begin
         if (c > 0) step(1'b1);
         if (frame_start === 1'b1) begin
            if (f1 < 0) begin f1 = c; fc1 = frame_cnt; end
            else        begin f2 = c; fc2 = frame_cnt; end
         end
         if (f1 >= 0 && f2 < 0 && vsync === 1'b0) begin
            vs_low++;
            if (vpos < 3'd5 || vpos > 3'd6) bad_vs++;
         end
      end
      checks++;
      if (f2 - f1 != HT * VT * DIV) begin
         failures++;
         $display("FAIL frame_period: got %0d cycles, want %0d", f2 - f1, HT * VT * DIV);
      end
      checks++;
      if (vs_low != VS * HT * DIV || bad_vs != 0) begin
         failures++;
         $display("FAIL vsync_window: got %0d low cycles (%0d outside 5..6), want 56 (0)", vs_low, bad_vs);
      end
      checks++;
      if (fc1 !== 8'd0 || fc2 !== 8'(FC_EN)) begin
         failures++;
         $display("FAIL frame_cnt: got %0d at first and %0d at second frame_start, want 0 and %0d",
                  fc1, fc2, FC_EN);
      end
   endtask

   task automatic test_freeze();
      bit found = 1'b0;
      do_reset();
      for (int c = 0; c < 100 && !found; c++) begin
         step(1'b1);
         if (hpos === 4'd5 && vpos === 3'd0) found = 1'b1;
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL freeze_reach: hpos=5 not reached, got h=%0d v=%0d", hpos, vpos);
      end
      for (int i = 0; i < 10; i++) begin
         step(1'b0);
         checks++;
         if ({pix_stb, hpos, vpos, display_on, hsync, vsync, line_start, frame_start}
             !== {1'b0, 4'd5, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL freeze_hold[%0d]: got stb=%b h=%0d v=%0d de=%b hs=%b vs=%b ls=%b fs=%b, want 0 5 0 1 1 1 0 0",
                     i, pix_stb, hpos, vpos, display_on, hsync, vsync, line_start, frame_start);
         end
      end
      // The prescaler advanced once before the freeze, so the strobe comes on the first resumed cycle.
      step(1'b1);
      checks++;
      if ({pix_stb, hpos} !== {1'b1, 4'd5}) begin
         failures++;
         $display("FAIL resume_stb: got stb=%b h=%0d, want stb=1 h=5", pix_stb, hpos);
      end
      step(1'b1);
      checks++;
      if (hpos !== 4'd6) begin
         failures++;
         $display("FAIL resume_pos: got h=%0d, want 6", hpos);
      end
   endtask

   // Reference model: position is the count of pixel strobes since reset, laid out row-major.
   task automatic test_random_ena();
      int   m_pix = 0, m_en = 0, errs = 0;
      bit   m_ls = 1'b0, m_fs = 1'b0;
      logic cur_en = 1'b1;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         bit          e_stb, e_de, e_hs, e_vs;
         int          lin, h, v, fc;
         logic [20:0] exp_v, act_v;
         if (i > 0) begin
            cur_en = ($urandom_range(3) != 0);
            step(cur_en);
         end
         e_stb = cur_en && ((m_en % DIV) == DIV - 1);
         if (m_pix == 0) begin
            h  = HT - 1;
            v  = VT - 1;
            fc = 0;
         end else begin
            lin = m_pix - 1;
            h   = lin % HT;
            v   = (lin / HT) % VT;
            fc  = FC_EN ? (lin / (HT * VT)) % 256 : 0;
         end
         e_de  = (h < HA) && (v < VA);
         e_hs  = !(h >= HA + HFP && h < HA + HFP + HS);
         e_vs  = !(v >= VA + VFP && v < VA + VFP + VS);
         exp_v = {e_stb, 4'(h), 3'(v), e_de, e_hs, e_vs, m_ls, m_fs, 8'(fc)};
         act_v = {pix_stb, hpos, vpos, display_on, hsync, vsync, line_start, frame_start, frame_cnt};
         checks++;
         if (act_v !== exp_v) begin
            failures++;
            errs++;
            if (errs <= 8)
               $display("FAIL random_model[%0d] ena=%b: got {stb,h,v,de,hs,vs,ls,fs,fc}=%h, want %h",
                        i, cur_en, act_v, exp_v);
         end
         if (cur_en) m_en++;
         if (e_stb) begin
            m_pix++;
            lin  = m_pix - 1;
            m_ls = (lin % HT) == 0;
            m_fs = (lin % (HT * VT)) == 0;
         end else begin
            m_ls = 1'b0;
            m_fs = 1'b0;
         end
      end
   endtask

   task automatic test_reset_mid();
      bit found = 1'b0;
      do_reset();
      for (int c = 0; c < 200 && !found; c++) begin
         step(1'b1);
         if (hpos === 4'd9 && vpos === 3'd2) found = 1'b1;
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL midreset_reach: (9,2) not reached, got h=%0d v=%0d", hpos, vpos);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({hpos, vpos, display_on, hsync, vsync, line_start, frame_start, frame_cnt, pix_stb}
          !== {4'(HT-1), 3'(VT-1), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0}) begin
         failures++;
         $display("FAIL midreset_async: got h=%0d v=%0d de=%b hs=%b vs=%b ls=%b fs=%b fc=%0d stb=%b, want 13 7 0 1 1 0 0 0 0",
                  hpos, vpos, display_on, hsync, vsync, line_start, frame_start, frame_cnt, pix_stb);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      step(1'b1);
      checks++;
      if ({pix_stb, hpos} !== {1'b1, 4'(HT-1)}) begin
         failures++;
         $display("FAIL midreset_first_stb: got stb=%b h=%0d, want 1 13", pix_stb, hpos);
      end
      step(1'b1);
      checks++;
      if ({hpos, vpos, line_start, frame_start} !== {4'd0, 3'd0, 1'b1, 1'b1}) begin
         failures++;
         $display("FAIL midreset_restart: got h=%0d v=%0d ls=%b fs=%b, want 0 0 1 1",
                  hpos, vpos, line_start, frame_start);
      end
   endtask

   task automatic test_default_640x480();
      int l1 = -1, l2 = -1, hs_low = 0, bad_hs = 0, de_low = 0;
      do_reset();
      checks++;
      if ({d_pix_stb, d_hpos, d_vpos} !== {1'b1, 10'd799, 10'd524}) begin
         failures++;
         $display("FAIL default_reset: got stb=%b h=%0d v=%0d, want 1 799 524", d_pix_stb, d_hpos, d_vpos);
      end
      for (int c = 0; c < 2000 && l2 < 0; c++) begin
         if (c > 0) step(1'b1);
         if (d_line_start === 1'b1) begin
            if (l1 < 0) l1 = c;
            else        l2 = c;
         end
         if (l1 >= 0 && l2 < 0) begin
            if (d_hsync === 1'b0) begin
               hs_low++;
               if (d_hpos < 10'd656 || d_hpos > 10'd751) bad_hs++;
            end
            if (d_display_on === 1'b0) de_low++;
         end
      end
      checks++;
      if (l1 != 1 || l2 - l1 != 800) begin
         failures++;
         $display("FAIL default_line: got first ls at %0d, period %0d, want 1 and 800", l1, l2 - l1);
      end
      checks++;
      if (hs_low != 96 || bad_hs != 0) begin
         failures++;
         $display("FAIL default_hsync: got %0d low cycles (%0d outside 656..751), want 96 (0)", hs_low, bad_hs);
      end
      checks++;
      if (de_low != 160) begin
         failures++;
         $display("FAIL default_blank: got %0d blank cycles, want 160", de_low);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      ena   = 1'b0;
      test_reset();
      test_line();
      test_frame();
      test_freeze();
      test_random_ena();
      test_reset_mid();
      test_default_640x480();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
